fofb_readout_streamer: RTL
==========================

# fofb_readout_streamer

Parametrised readout-memory-to-stream engine on `sysClk`. On each completed FOFB snapshot it scans a synchronous-read readout memory and emits one beat per entry on a valid/ready stream toward the correction DSP. It adds runtime scan length, optional suppression of absent entries, output backpressure, one-deep request queuing and overrun accounting, none of which the fixed-width streamer it supersedes provides.

## Interface
- `READOUT_WIDTH`, 8, memory address / beat index width; memory depth 2^READOUT_WIDTH
- `DATA_WIDTH`, 96, entry data width, e.g. {X,Y,S} at 32 bits each
- `OVERRUN_WIDTH`, 16, width of the saturating overrun counter

Ports:
- `sysClk`  in  1  sole clock
- `sysReset`  in  1  reset, asynchronous, active-high
- `readoutActive`  in  1  high while the snapshot is being written; scans never start while high
- `readoutValid`  in  1  snapshot complete; its rising edge requests a scan
- `scanCount`  in  READOUT_WIDTH+1  number of entries to scan, from index 0; sampled at scan start
- `skipAbsent`  in  1  1 = emit only present entries; sampled at scan start
- `readoutAddress`  out  READOUT_WIDTH  registered memory read address
- `readoutData`  in  DATA_WIDTH  memory data, valid 1 cycle after the address
- `readoutPresent`  in  1  entry-present flag, same timing as `readoutData`
- `index`  out  READOUT_WIDTH  beat index
- `data`  out  DATA_WIDTH  beat data
- `present`  out  1  beat present flag, always 1 when `skipAbsent` is set
- `valid`  out  1  beat valid
- `ready`  in  1  downstream accept; a beat transfers on `valid & ready`
- `busy`  out  1  scan or drain in progress
- `doneStrobe`  out  1  one-cycle pulse when a scan completes
- `overrunCount`  out  OVERRUN_WIDTH  dropped scan requests, saturating

## Operation
- Request: `req = readoutValid & ~readoutValid_d & ~readoutActive`, where `readoutValid_d` is `readoutValid` registered once.
- FSM states:
  - IDLE: on `req`, or with `pending` set, latch `scanCount` and `skipAbsent`, clear `pending`, go to SCAN.
  - SCAN: issue addresses 0..scanCount-1, one per cycle. Hold the address when the 2-entry output FIFO occupancy plus the in-flight read would exceed 2. After the final address, go to DRAIN.
  - DRAIN: wait until the in-flight read is done and the FIFO is empty, pulse `doneStrobe`, go to IDLE.
- Return path: one cycle after each issued address, push {address, data, present} into the FIFO. When the latched `skipAbsent`=1 and `readoutPresent`=0, discard the entry instead of pushing it.
- `scanCount`=0: SCAN immediately goes to DRAIN. No beats are emitted and `doneStrobe` still pulses.
- `scanCount` above 2^READOUT_WIDTH is clamped to 2^READOUT_WIDTH.
- `req` while `busy`:
  - `pending` clear: set `pending`.
  - `pending` already set: increment `overrunCount`, saturating at all-ones, and keep the existing request.
- `req` in the same cycle as the DRAIN-to-IDLE transition counts as `req` while `busy`.
- `busy` = state != IDLE.
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, `pending` clear, `overrunCount` 0.
- Reset asserted mid-scan aborts the scan with no `doneStrobe`. The next `req` after reset release starts again at index 0.

## Timing
- `req` is detected in cycle N. Address 0 is driven in N+1, data returns in N+2, and the beat is `valid` in N+3.
- With `ready` held high and all entries pushed, throughput is 1 beat per cycle. The last beat is valid at N+2+scanCount.
- `doneStrobe` asserts the cycle after the final beat is accepted, or the cycle after the FIFO becomes empty if the final entries were discarded.
- While `valid & ~ready`: `index`, `data` and `present` stay stable and `valid` stays high.
- Beats are never lost, duplicated or reordered. Indices within a scan are strictly increasing.
- A pending scan begins in the cycle after IDLE is re-entered.

## Test plan
- `scanCount`=4, `skipAbsent`=0, all entries present, `ready`=1: beats with index 0,1,2,3 on consecutive cycles starting at N+3, data matches memory, `doneStrobe` at N+7.
- `scanCount`=8, `skipAbsent`=1, entries present only at indices 2 and 5: exactly two beats, index 2 then index 5, then one `doneStrobe`.
- `scanCount`=16, `ready` toggling 1,0,0,1: all 16 beats in order with no loss or duplication, and outputs stable during every stall.
- Three `readoutValid` rising edges during one busy scan: exactly one extra scan runs afterwards, and `overrunCount` reads 2.
- `sysReset` pulsed at beat 5 of 10: `valid`, `busy` and `index` read 0 immediately, no `doneStrobe`, and the next edge emits beats from index 0.
- `scanCount`=0: no beats, `doneStrobe` pulses once at N+2, `busy` high only in N+1.

Source files
------------

// File: rtl/fofb_readout_streamer.sv
// Snapshot-triggered scanner: reads a synchronous readout memory from index 0 and
// streams one beat per entry (optionally present-only) over a valid/ready interface.
module fofb_readout_streamer #(
    parameter int READOUT_WIDTH = 8,
    parameter int DATA_WIDTH    = 96,
    parameter int OVERRUN_WIDTH = 16
) (
    input  logic                     sysClk,
    input  logic                     sysReset,
    input  logic                     readoutActive,
    input  logic                     readoutValid,
    input  logic [READOUT_WIDTH:0]   scanCount,
    input  logic                     skipAbsent,
    output logic [READOUT_WIDTH-1:0] readoutAddress,
    input  logic [DATA_WIDTH-1:0]    readoutData,
    input  logic                     readoutPresent,
    output logic [READOUT_WIDTH-1:0] index,
    output logic [DATA_WIDTH-1:0]    data,
    output logic                     present,
    output logic                     valid,
    input  logic                     ready,
    output logic                     busy,
    output logic                     doneStrobe,
    output logic [OVERRUN_WIDTH-1:0] overrunCount
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int ENT_W = READOUT_WIDTH + DATA_WIDTH + 1;

    localparam logic [READOUT_WIDTH:0]   DEPTH     = {1'b1, {READOUT_WIDTH{1'b0}}};
    localparam logic [READOUT_WIDTH:0]   CNT_ZERO  = {(READOUT_WIDTH+1){1'b0}};
    localparam logic [READOUT_WIDTH:0]   CNT_ONE   = {{READOUT_WIDTH{1'b0}}, 1'b1};
    localparam logic [READOUT_WIDTH-1:0] ADDR_ZERO = {READOUT_WIDTH{1'b0}};
    localparam logic [READOUT_WIDTH-1:0] ADDR_ONE  = {{(READOUT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [OVERRUN_WIDTH-1:0] OVR_ZERO  = {OVERRUN_WIDTH{1'b0}};
    localparam logic [OVERRUN_WIDTH-1:0] OVR_ONE   = {{(OVERRUN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [OVERRUN_WIDTH-1:0] OVR_MAX   = {OVERRUN_WIDTH{1'b1}};
    localparam logic [ENT_W-1:0]         ENT_ZERO  = {ENT_W{1'b0}};

    logic [1:0]               state_q, state_d;
    logic                     rv_q;
    logic                     pend_q, pend_d;
    logic [READOUT_WIDTH:0]   cnt_q, cnt_d;
    logic                     skip_q, skip_d;
    logic [READOUT_WIDTH-1:0] addr_q, addr_d;
    logic                     rd_pend_q, rd_pend_d;
    logic [READOUT_WIDTH-1:0] rd_idx_q, rd_idx_d;
    logic                     v0_q, v0_d, v1_q, v1_d;
    logic [ENT_W-1:0]         ent0_q, ent0_d, ent1_q, ent1_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;
    logic [OVERRUN_WIDTH-1:0] ovr_q, ovr_d;

    logic                     req_s, pop_s, push_s, issue_s, last_s, finish_s, busy_s;
    logic [2:0]               occ_s;
    logic [READOUT_WIDTH:0]   clamp_s;
    logic [ENT_W-1:0]         new_s;

    assign req_s    = readoutValid & ~rv_q & ~readoutActive;
    assign busy_s   = (state_q != ST_IDLE);
    assign pop_s    = v0_q & ready;
    assign push_s   = rd_pend_q & (~skip_q | readoutPresent);
    assign new_s    = {rd_idx_q, readoutData, readoutPresent};
    assign clamp_s  = (scanCount > DEPTH) ? DEPTH : scanCount;
    // Queued beats plus the read in flight, after this cycle's pop; a new read needs a free slot.
    assign occ_s    = {2'b00, v0_q} + {2'b00, v1_q} + {2'b00, rd_pend_q} - {2'b00, pop_s};
    assign issue_s  = (state_q == ST_SCAN) && (cnt_q != CNT_ZERO) && (occ_s <= 3'd1);
    assign last_s   = ({1'b0, addr_q} == (cnt_q - CNT_ONE));
    assign finish_s = ~rd_pend_q & ~v1_q & (~v0_q | pop_s);

    assign readoutAddress = addr_q;
    assign {index, data, present} = ent0_q;
    assign valid        = v0_q;
    assign busy         = busy_q;
    assign doneStrobe   = done_q;
    assign overrunCount = ovr_q;

    // Scan sequencing, request queuing and overrun accounting.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        skip_d    = skip_q;
        addr_d    = addr_q;
        done_d    = 1'b0;
        ovr_d     = ovr_q;
        rd_pend_d = issue_s;
        rd_idx_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s || pend_q) begin
                    cnt_d   = clamp_s;
                    skip_d  = skipAbsent;
                    addr_d  = ADDR_ZERO;
                    pend_d  = pend_q & req_s;
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (cnt_q == CNT_ZERO) begin
                    // Empty scan: nothing can be in flight, so it completes at once.
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (issue_s) begin
                    if (last_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_DRAIN: begin
                if (finish_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (busy_s && req_s) begin
            if (pend_q) begin
                if (ovr_q != OVR_MAX) begin
                    ovr_d = ovr_q + OVR_ONE;
                end else begin
                    ovr_d = ovr_q;
                end
            end else begin
                pend_d = 1'b1;
            end
        end else begin
            ovr_d = ovr_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Two-entry output queue; slot 0 is the beat presented downstream.
    always_comb begin
        v0_d   = v0_q;
        v1_d   = v1_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        if (pop_s) begin
            if (v1_q) begin
                ent0_d = ent1_q;
                if (push_s) begin
                    ent1_d = new_s;
                end else begin
                    v1_d = 1'b0;
                end
            end else if (push_s) begin
                ent0_d = new_s;
            end else begin
                v0_d = 1'b0;
            end
        end else if (push_s) begin
            if (v0_q) begin
                ent1_d = new_s;
                v1_d   = 1'b1;
            end else begin
                ent0_d = new_s;
                v0_d   = 1'b1;
            end
        end else begin
            v0_d = v0_q;
        end
    end

    // State registers.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            state_q   <= ST_IDLE;
            rv_q      <= 1'b0;
            pend_q    <= 1'b0;
            cnt_q     <= CNT_ZERO;
            skip_q    <= 1'b0;
            addr_q    <= ADDR_ZERO;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= ADDR_ZERO;
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            ent0_q    <= ENT_ZERO;
            ent1_q    <= ENT_ZERO;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovr_q     <= OVR_ZERO;
        end else begin
            state_q   <= state_d;
            rv_q      <= readoutValid;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            skip_q    <= skip_d;
            addr_q    <= addr_d;
            rd_pend_q <= rd_pend_d;
            rd_idx_q  <= rd_idx_d;
            v0_q      <= v0_d;
            v1_q      <= v1_d;
            ent0_q    <= ent0_d;
            ent1_q    <= ent1_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
        end
    end

endmodule
